// File: rtl/exe_muldiv_if.sv
// exe_muldiv_if: issue and write-back bundle of the EXE-stage mul/div unit.
// The master issues operations; the slave returns HI/LO results and stall status.
interface exe_muldiv_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        stall_req;
   logic        busy;
   logic        done;
   logic        hi_wena;
   logic        lo_wena;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic        div_by_zero;

   modport master (
      output start, op, a, b, flush,
      input  stall_req, busy, done, hi_wena, lo_wena,
      input  hi_out, lo_out, div_by_zero
   );

   modport slave (
      input  start, op, a, b, flush,
      output stall_req, busy, done, hi_wena, lo_wena,
      output hi_out, lo_out, div_by_zero
   );
endinterface

// File: rtl/exe_muldiv.sv
// exe_muldiv: iterative MULT/MULTU/DIV/DIVU unit for the EXE stage.
// Multi-cycle multiply plus radix-2 restoring divide with sign fix-up.
module exe_muldiv #(
   parameter int MUL_CYCLES = 2
) (
   input logic          clk,
   input logic          rst,
   exe_muldiv_if.slave  bus
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] MUL  = 3'd1;
   localparam logic [2:0] DIV  = 3'd2;
   localparam logic [2:0] FIX  = 3'd3;
   localparam logic [2:0] DONE = 3'd4;

   localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);

   logic [2:0]  state;
   logic [2:0]  state_nx;
   logic [4:0]  cnt;
   logic [31:0] a_r;
   logic [31:0] b_r;
   logic        sign_a;
   logic        sign_b;
   logic [31:0] rem;
   logic [31:0] quo;
   logic [31:0] dvs;
   logic        busy_r;
   logic [31:0] hi_r;
   logic [31:0] lo_r;
   logic        dz_r;

   logic        is_signed;
   logic        b_zero;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [63:0] prod;
   logic [32:0] rem_sh;
   logic [31:0] quo_sh;
   logic        rem_ge;
   logic [31:0] rem_sub;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   assign is_signed = ~bus.op[0];
   assign b_zero    = (bus.b == 32'd0);
   assign a_mag     = (is_signed & bus.a[31]) ? -bus.a : bus.a;
   assign b_mag     = (is_signed & bus.b[31]) ? -bus.b : bus.b;

   // sign bits are zero for unsigned ops, so extension covers both cases
   assign prod = {{32{sign_a}}, a_r} * {{32{sign_b}}, b_r};

   assign rem_sh  = {rem, quo[31]};
   assign quo_sh  = {quo[30:0], 1'b0};
   assign rem_ge  = (rem_sh >= {1'b0, dvs});
   assign rem_sub = rem_sh[31:0] - dvs;

   assign quo_fix = (sign_a ^ sign_b) ? -quo : quo;
   assign rem_fix = sign_a ? -rem : rem;

   always_comb begin
      state_nx = state;
      if (bus.flush) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (!bus.op[1])  state_nx = MUL;
                  else if (b_zero) state_nx = DONE;
                  else             state_nx = DIV;
               end
            end
            MUL:     if (cnt == MUL_LAST) state_nx = DONE;
            DIV:     if (cnt == 5'd31)    state_nx = FIX;
            FIX:     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= '0;
         a_r    <= '0;
         b_r    <= '0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         rem    <= '0;
         quo    <= '0;
         dvs    <= '0;
         busy_r <= 1'b0;
         hi_r   <= '0;
         lo_r   <= '0;
         dz_r   <= 1'b0;
      end else begin
         state  <= state_nx;
         busy_r <= (state_nx == MUL) |
                   (state_nx == DIV) |
                   (state_nx == FIX);
         if (!bus.flush) begin
            case (state)
               IDLE: begin
                  if (bus.start) begin
                     a_r    <= bus.a;
                     b_r    <= bus.b;
                     sign_a <= is_signed & bus.a[31];
                     sign_b <= is_signed & bus.b[31];
                     cnt    <= '0;
                     rem    <= '0;
                     quo    <= a_mag;
                     dvs    <= b_mag;
                     dz_r   <= bus.op[1] & b_zero;
                     if (bus.op[1] & b_zero) begin
                        hi_r <= bus.a;
                        lo_r <= 32'hFFFF_FFFF;
                     end
                  end
               end
               MUL: begin
                  cnt <= cnt + 5'd1;
                  if (cnt == MUL_LAST) begin
                     hi_r <= prod[63:32];
                     lo_r <= prod[31:0];
                  end
               end
               DIV: begin
                  cnt <= cnt + 5'd1;
                  rem <= rem_ge ? rem_sub : rem_sh[31:0];
                  quo <= {quo_sh[31:1], rem_ge};
               end
               FIX: begin
                  hi_r <= rem_fix;
                  lo_r <= quo_fix;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.busy        = busy_r;
   assign bus.stall_req   = busy_r | ((state == IDLE) & bus.start);
   assign bus.done        = (state == DONE) & ~bus.flush;
   assign bus.hi_wena     = bus.done;
   assign bus.lo_wena     = bus.done;
   assign bus.hi_out      = hi_r;
   assign bus.lo_out      = lo_r;
   assign bus.div_by_zero = dz_r;

endmodule

// File: tb/tb_exe_muldiv.sv
// tb_exe_muldiv: scoreboard bench for the iterative mul/div unit.
// Expected results are queued at issue and popped when done pulses.
module tb_exe_muldiv;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } res_t;

   localparam int MC = 2;

   logic clk;
   logic rst;
   int   vectors;
   int   errors;
   res_t sb[$];
   res_t e;

   exe_muldiv_if bus ();

   exe_muldiv #(.MUL_CYCLES(MC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic res_t model(input logic [1:0] o,
                                  input logic [31:0] x,
                                  input logic [31:0] y);
      longint sx, sy, p, q, r;
      res_t   m;
      sx = o[0] ? longint'({32'b0, x}) : longint'($signed(x));
      sy = o[0] ? longint'({32'b0, y}) : longint'($signed(y));
      m.dz = 1'b0;
      if (!o[1]) begin
         p = sx * sy;
         m.hi = p[63:32];
         m.lo = p[31:0];
      end else if (y == 32'd0) begin
         m.hi = x;
         m.lo = 32'hFFFF_FFFF;
         m.dz = 1'b1;
      end else begin
         q = sx / sy;
         r = sx % sy;
         m.hi = r[31:0];
         m.lo = q[31:0];
      end
      return m;
   endfunction

   function automatic int exp_lat(input logic [1:0] o,
                                  input logic [31:0] y);
      if (!o[1]) return MC + 1;
      if (y == 32'd0) return 1;
      return 34;
   endfunction

   task automatic issue(input logic [1:0] o,
                        input logic [31:0] x,
                        input logic [31:0] y);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = o;
      bus.a     = x;
      bus.b     = y;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         bus.start = 1'b0;
         lat++;
      end while (!bus.done && lat < 100);
   endtask

   task automatic test_reset;
      rst = 1'b0;
      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.a     = '0;
      bus.b     = '0;
      bus.flush = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({bus.hi_out, bus.lo_out} !== 64'd0 ||
          {bus.busy, bus.done, bus.hi_wena, bus.lo_wena,
           bus.div_by_zero, bus.stall_req} !== 6'd0) begin
         errors++;
         $display("FAIL reset: hi=%h lo=%h busy=%b done=%b required all 0",
                  bus.hi_out, bus.lo_out, bus.busy, bus.done);
      end
      rst = 1'b1;
   endtask

   task automatic test_mult;
      logic [3:0] stl;
      logic [3:0] dn;
      issue(2'b00, 32'hFFFF_FFFD, 32'd5);
      sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0});
      #1;
      stl[0] = bus.stall_req;
      dn[0]  = bus.done;
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
         stl[k] = bus.stall_req;
         dn[k]  = bus.done;
      end
      vectors++;
      if (stl !== 4'b0111) begin
         errors++;
         $display("FAIL mult_stall: got %b required 0111", stl);
      end
      vectors++;
      if (dn !== 4'b1000) begin
         errors++;
         $display("FAIL mult_latency: done %b required 1000", dn);
      end
      e = sb.pop_front();
      vectors++;
      if ({bus.hi_out, bus.lo_out} !== {e.hi, e.lo}) begin
         errors++;
         $display("FAIL mult_result: got %h_%h required %h_%h",
                  bus.hi_out, bus.lo_out, e.hi, e.lo);
      end
   endtask

   task automatic test_multu;
      int lat;
      issue(2'b01, 32'hFFFF_FFFF, 32'd2);
      sb.push_back('{32'h0000_0001, 32'hFFFF_FFFE, 1'b0});
      wait_done(lat);
      e = sb.pop_front();
      vectors++;
      if ({bus.hi_out, bus.lo_out} !== {e.hi, e.lo} ||
          {bus.hi_wena, bus.lo_wena} !== 2'b11) begin
         errors++;
         $display("FAIL multu: got %h_%h wena=%b%b required %h_%h 11",
                  bus.hi_out, bus.lo_out, bus.hi_wena, bus.lo_wena,
                  e.hi, e.lo);
      end
      @(negedge clk);
      vectors++;
      if ({bus.hi_wena, bus.lo_wena, bus.done} !== 3'b000 ||
          bus.lo_out !== 32'hFFFF_FFFE) begin
         errors++;
         $display("FAIL multu_pulse: wena=%b%b lo=%h required 00 hold",
                  bus.hi_wena, bus.lo_wena, bus.lo_out);
      end
   endtask

   task automatic test_div;
      logic [1:0]  ops [4] = '{2'b11, 2'b10, 2'b10, 2'b11};
      logic [31:0] as  [4] = '{32'd100, 32'hFFFF_FFF9,
                               32'h8000_0000, 32'h0000_1234};
      logic [31:0] bs  [4] = '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0};
      res_t        ex  [4] = '{'{32'd2, 32'd14, 1'b0},
                               '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0},
                               '{32'd0, 32'h8000_0000, 1'b0},
                               '{32'h1234, 32'hFFFF_FFFF, 1'b1}};
      int lat;
      for (int i = 0; i < 4; i++) begin
         issue(ops[i], as[i], bs[i]);
         sb.push_back(ex[i]);
         wait_done(lat);
         e = sb.pop_front();
         vectors++;
         if (lat != exp_lat(ops[i], bs[i])) begin
            errors++;
            $display("FAIL div_latency[%0d]: got %0d required %0d",
                     i, lat, exp_lat(ops[i], bs[i]));
         end
         vectors++;
         if ({bus.hi_out, bus.lo_out, bus.div_by_zero} !==
             {e.hi, e.lo, e.dz}) begin
            errors++;
            $display("FAIL div[%0d]: got %h_%h dz=%b required %h_%h dz=%b",
                     i, bus.hi_out, bus.lo_out, bus.div_by_zero,
                     e.hi, e.lo, e.dz);
         end
      end
   endtask

   task automatic test_flush;
      int  lat;
      logic seen;
      seen = 1'b0;
      issue(2'b10, 32'd1000, 32'd3);
      @(negedge clk);
      bus.start = 1'b0;
      vectors++;
      if (bus.div_by_zero !== 1'b0 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL flush_dz_clear: dz=%b busy=%b required 0 1",
                  bus.div_by_zero, bus.busy);
      end
      for (int k = 2; k <= 10; k++) begin
         @(negedge clk);
         seen |= bus.done;
      end
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      seen |= bus.done;
      vectors++;
      if (bus.busy !== 1'b0 || seen !== 1'b0 ||
          {bus.hi_out, bus.lo_out} !== {32'h1234, 32'hFFFF_FFFF}) begin
         errors++;
         $display("FAIL flush: busy=%b done_seen=%b hi=%h lo=%h required 0 0 1234 ffffffff",
                  bus.busy, seen, bus.hi_out, bus.lo_out);
      end
      issue(2'b00, 32'd6, 32'd7);
      sb.push_back('{32'd0, 32'd42, 1'b0});
      wait_done(lat);
      e = sb.pop_front();
      vectors++;
      if ({bus.hi_out, bus.lo_out} !== {e.hi, e.lo} || lat != MC + 1) begin
         errors++;
         $display("FAIL flush_next: got %h_%h lat=%0d required %h_%h lat=%0d",
                  bus.hi_out, bus.lo_out, lat, e.hi, e.lo, MC + 1);
      end
      @(negedge clk);
      bus.start = 1'b1;
      bus.flush = 1'b1;
      bus.op    = 2'b01;
      @(negedge clk);
      bus.start = 1'b0;
      bus.flush = 1'b0;
      vectors++;
      if (bus.busy !== 1'b0 || bus.lo_out !== 32'd42) begin
         errors++;
         $display("FAIL flush_start: busy=%b lo=%h required 0 0000002a",
                  bus.busy, bus.lo_out);
      end
   endtask

   task automatic test_busy_start;
      int lat;
      issue(2'b11, 32'd100, 32'd7);
      sb.push_back(model(2'b11, 32'd100, 32'd7));
      repeat (3) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      bus.start = 1'b1;
      bus.op    = 2'b00;
      bus.a     = 32'd1;
      bus.b     = 32'd1;
      wait_done(lat);
      e = sb.pop_front();
      vectors++;
      if ({bus.hi_out, bus.lo_out} !== {e.hi, e.lo} || lat != 31) begin
         errors++;
         $display("FAIL busy_start: got %h_%h lat=%0d required %h_%h lat=31",
                  bus.hi_out, bus.lo_out, lat, e.hi, e.lo);
      end
   endtask

   task automatic test_reset_mid;
      logic seen;
      seen = 1'b0;
      issue(2'b10, 32'h7FFF_0000, 32'd9);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (19) @(negedge clk);
      rst = 1'b0;
      #1;
      vectors++;
      if ({bus.hi_out, bus.lo_out} !== 64'd0 ||
          {bus.busy, bus.done, bus.hi_wena, bus.lo_wena,
           bus.div_by_zero, bus.stall_req} !== 6'd0) begin
         errors++;
         $display("FAIL reset_mid: hi=%h lo=%h busy=%b required all 0",
                  bus.hi_out, bus.lo_out, bus.busy);
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (40) begin
         @(negedge clk);
         seen |= bus.hi_wena | bus.lo_wena | bus.done;
      end
      vectors++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL reset_after: wena seen=%b required 0", seen);
      end
   endtask

   task automatic test_random;
      int          lat;
      logic [1:0]  o;
      logic [31:0] x, y;
      for (int i = 0; i < 10; i++) begin
         o = 2'($urandom_range(0, 3));
         x = $urandom;
         y = (i == 3) ? 32'd0 : ((i & 1) != 0 ? 32'($urandom_range(1, 300)) : $urandom);
         issue(o, x, y);
         sb.push_back(model(o, x, y));
         wait_done(lat);
         e = sb.pop_front();
         vectors++;
         if ({bus.hi_out, bus.lo_out, bus.div_by_zero} !== {e.hi, e.lo, e.dz} ||
             lat != exp_lat(o, y)) begin
            errors++;
            $display("FAIL random[%0d] op=%b a=%h b=%h: got %h_%h dz=%b lat=%0d required %h_%h dz=%b lat=%0d",
                     i, o, x, y, bus.hi_out, bus.lo_out, bus.div_by_zero, lat,
                     e.hi, e.lo, e.dz, exp_lat(o, y));
         end
      end
   endtask

   initial begin
      vectors = 0;
      errors  = 0;
      test_reset();
      test_mult();
      test_multu();
      test_div();
      test_flush();
      test_busy_start();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
